fp_align_add_pipe: RTL and testbench
====================================

// Module: fp_align_add_pipe
// PURPOSE
//  Parametrised, handshaked successor to the single-stage FP adder front end.
//  Two-stage pipeline: (1) capture, magnitude-compare and swap; (2) exponent align with guard/round/sticky, then mantissa add/sub.
//  Supports add or subtract per transaction, flushes denormal inputs to zero and supports backpressure.
//  Feeds the normalise/round stage with an unnormalised mantissa, exponent and sign.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   23   stored fraction width; MW = MAN_W+1 includes the hidden bit
//  (derived) OUT_W = MW+4: carry + MW + guard/round/sticky
// PORTS
//  clk        in   1            rising-edge clock
//  reset_n    in   1            asynchronous reset, active-low
//  in_valid   in   1            operand pair valid
//  in_ready   out  1            stage 1 can accept
//  op_sub     in   1            1: compute A-B, 0: compute A+B
//  op_a       in   1+EXP_W+MAN_W  operand A {sign,exp,frac}
//  op_b       in   1+EXP_W+MAN_W  operand B
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts
//  mant_out   out  OUT_W        {carry, MW-bit mantissa, G, R, S}
//  exp_out    out  EXP_W        exponent of larger-magnitude operand
//  sign_out   out  1            result sign
//  zero_out   out  1            exact zero result
//  nan_out    out  1            FPADD_SPECIAL_EN only
//  inf_out    out  1            FPADD_SPECIAL_EN only
// BEHAVIOUR
//  Reset: all pipeline valids are 0 and all output registers are 0; in_ready is 1 once reset is released.
//  Handshake: a transfer occurs when valid&&ready. s2_adv = !out_valid || out_ready.
//   in_ready = !s1_valid || s2_adv. This is combinational from out_ready and has no other comb paths.
//   Latency is 2 cycles at full throughput (1 transaction/cycle). out_* are held stable while out_valid&&!out_ready.
//  Stage 1 (registered):
//   - eff_sign_b = sign_b ^ op_sub.
//   - exp==0 flushes the operand to zero: hidden bit 0, fraction ignored.
//   - Swap so that {exp,frac} of L >= that of S; ties keep A as L.
//  Stage 2 (registered outputs):
//   - d = exp_L - exp_S. ext_S = {hid_S,frac_S,3'b000} >> d.
//   - S bit = OR of all bits shifted out, including the incoming sticky.
//   - If d >= MW+3, ext_S = {(MW+2)'b0, |mant_S}.
//   - Effective subtract = sign_L ^ eff_sign_b_S. mant_out = ext_L + ext_S or ext_L - ext_S.
//     Zero-extend to OUT_W; no underflow because |L| >= |S|.
//   - exp_out = exp_L; sign_out = sign of L.
//   - Exact cancellation, or both inputs zero: mant_out=0, exp_out=0, sign_out=0, zero_out=1.
//  Reset asserted mid-operation: in-flight transactions are discarded and out_valid drops asynchronously.
//  A simultaneous input accept and output drain in the same cycle is legal and loses no data.
// CONFIGURATION
//  FPADD_SPECIAL_EN defined:
//   - exp all-ones is decoded in stage 1.
//   - Any NaN input, or Inf-Inf with effective subtract: nan_out=1, exp_out=all-ones, mant_out=0.
//   - Otherwise any Inf input: inf_out=1, exp_out=all-ones, mant_out=0, sign_out = that Inf's effective sign.
//  FPADD_SPECIAL_EN undefined:
//   - nan_out/inf_out ports are absent.
//   - An all-ones exponent is treated as an ordinary finite value.
// TESTING
//  1. A=3F800000, B=3F800000, op_sub=0 -> 2 cycles later mant_out=28'h8000000, exp_out=7F, sign_out=0, zero_out=0.
//  2. A=3F800000, B=3F800000, op_sub=1 -> mant_out=0, exp_out=0, sign_out=0, zero_out=1.
//  3. A=40000000, B=BF800000, op_sub=0 -> mant_out=28'h2000000, exp_out=80, sign_out=0.
//  4. A=3F800000, B=33800000 (d=24) -> mant_out=28'h4000004 (guard set).
//     Same with B=2B800000 (d=40) -> mant_out=28'h4000001 (sticky only).
//  5. 4 back-to-back inputs with out_ready=0 for 4 cycles:
//     -> in_ready falls after 2 accepts, no loss, results emerge in order, held stable while stalled.
//  6. reset_n pulsed low with 2 in flight -> out_valid=0 immediately, outputs 0, next input completes normally.
//     With FPADD_SPECIAL_EN: A=7F800000, B=7F800000, op_sub=1 -> nan_out=1.

Source files
------------

// File: rtl/fp_align_add_pipe_if.sv
// Handshaked operand/result bundle for the fp_align_add_pipe front end.
// Optional nan_out/inf_out exist only when FPADD_SPECIAL_EN is defined.
interface fp_align_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int MW    = MAN_W + 1;
    localparam int OUT_W = MW + 4;

    logic                   in_valid;
    logic                   in_ready;
    logic                   op_sub;
    logic [EXP_W+MAN_W:0]   op_a;
    logic [EXP_W+MAN_W:0]   op_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       mant_out;
    logic [EXP_W-1:0]       exp_out;
    logic                   sign_out;
    logic                   zero_out;
`ifdef FPADD_SPECIAL_EN
    logic                   nan_out;
    logic                   inf_out;
`endif

    // Producer/consumer side: drives operands, accepts results.
    modport master (
        output in_valid, op_sub, op_a, op_b, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out, zero_out
`ifdef FPADD_SPECIAL_EN
        , input nan_out, inf_out
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, op_sub, op_a, op_b, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out, zero_out
`ifdef FPADD_SPECIAL_EN
        , output nan_out, inf_out
`endif
    );
endinterface

// File: rtl/fp_align_add_pipe.sv
// Two-stage FP add front end: capture/compare/swap, then align (G/R/S) and add/sub.
// Define FPADD_SPECIAL_EN to decode NaN/Inf operands and drive nan_out/inf_out.
module fp_align_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              reset_n,
    fp_align_add_pipe_if.slave bus
);
    localparam int MW    = MAN_W + 1;
    localparam int EXT_W = MW + 3;
    localparam int OUT_W = MW + 4;
    localparam int FW    = EXP_W + MAN_W;

    // ---------------- stage 1 decode ----------------
    logic               sign_a_s;
    logic               sign_b_s;
    logic [EXP_W-1:0]   exp_a_s;
    logic [EXP_W-1:0]   exp_b_s;
    logic               hid_a_s;
    logic               hid_b_s;
    logic [MAN_W-1:0]   frac_a_s;
    logic [MAN_W-1:0]   frac_b_s;
    logic               a_is_l_s;
    logic               s2_adv_s;
    logic               in_ready_s;
    logic               s1_load_s;
    logic               s2_load_s;

    logic               s1_valid_r;
    logic               s1_sign_l_r;
    logic [EXP_W-1:0]   s1_exp_l_r;
    logic [MW-1:0]      s1_man_l_r;
    logic               s1_sign_s_r;
    logic [EXP_W-1:0]   s1_exp_s_r;
    logic [MW-1:0]      s1_man_s_r;

    logic               out_valid_r;
    logic [OUT_W-1:0]   mant_r;
    logic [EXP_W-1:0]   exp_r;
    logic               sign_r;
    logic               zero_r;

    // Field split, denormal flush and magnitude compare; B carries its effective sign.
    always_comb begin
        sign_a_s = bus.op_a[FW];
        exp_a_s  = bus.op_a[FW-1:MAN_W];
        hid_a_s  = (exp_a_s != {EXP_W{1'b0}});
        frac_a_s = hid_a_s ? bus.op_a[MAN_W-1:0] : {MAN_W{1'b0}};
        sign_b_s = bus.op_b[FW] ^ bus.op_sub;
        exp_b_s  = bus.op_b[FW-1:MAN_W];
        hid_b_s  = (exp_b_s != {EXP_W{1'b0}});
        frac_b_s = hid_b_s ? bus.op_b[MAN_W-1:0] : {MAN_W{1'b0}};
        // Ties keep A as the larger operand.
        a_is_l_s = ({exp_a_s, frac_a_s} >= {exp_b_s, frac_b_s});
    end

    // Pipeline flow control; in_ready is the only combinational path (from out_ready).
    always_comb begin
        s2_adv_s   = !out_valid_r || bus.out_ready;
        in_ready_s = !s1_valid_r || s2_adv_s;
        s1_load_s  = bus.in_valid && in_ready_s;
        s2_load_s  = s1_valid_r && s2_adv_s;
    end

    assign bus.in_ready = in_ready_s;

`ifdef FPADD_SPECIAL_EN
    logic               max_a_s;
    logic               max_b_s;
    logic               inf_a_s;
    logic               inf_b_s;
    logic               nan_s;
    logic               inf_s;
    logic               inf_sign_s;
    logic               s1_nan_r;
    logic               s1_inf_r;
    logic               s1_inf_sign_r;

    // NaN/Inf classification of the raw operands.
    always_comb begin
        max_a_s    = &exp_a_s;
        max_b_s    = &exp_b_s;
        inf_a_s    = max_a_s && (frac_a_s == {MAN_W{1'b0}});
        inf_b_s    = max_b_s && (frac_b_s == {MAN_W{1'b0}});
        nan_s      = (max_a_s && !inf_a_s) || (max_b_s && !inf_b_s) ||
                     (inf_a_s && inf_b_s && (sign_a_s ^ sign_b_s));
        inf_s      = !nan_s && (inf_a_s || inf_b_s);
        inf_sign_s = inf_a_s ? sign_a_s : sign_b_s;
    end

    // Stage 1 special-case flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_nan_r      <= 1'b0;
            s1_inf_r      <= 1'b0;
            s1_inf_sign_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_nan_r      <= nan_s;
            s1_inf_r      <= inf_s;
            s1_inf_sign_r <= inf_sign_s;
        end
    end
`endif

    // Stage 1 register: valid plus swapped L/S operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_sign_l_r <= 1'b0;
            s1_exp_l_r  <= {EXP_W{1'b0}};
            s1_man_l_r  <= {MW{1'b0}};
            s1_sign_s_r <= 1'b0;
            s1_exp_s_r  <= {EXP_W{1'b0}};
            s1_man_s_r  <= {MW{1'b0}};
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= bus.in_valid;
            end
            if (s1_load_s) begin
                s1_sign_l_r <= a_is_l_s ? sign_a_s : sign_b_s;
                s1_exp_l_r  <= a_is_l_s ? exp_a_s : exp_b_s;
                s1_man_l_r  <= a_is_l_s ? {hid_a_s, frac_a_s} : {hid_b_s, frac_b_s};
                s1_sign_s_r <= a_is_l_s ? sign_b_s : sign_a_s;
                s1_exp_s_r  <= a_is_l_s ? exp_b_s : exp_a_s;
                s1_man_s_r  <= a_is_l_s ? {hid_b_s, frac_b_s} : {hid_a_s, frac_a_s};
            end
        end
    end

    // ---------------- stage 2 align and add ----------------
    logic [EXP_W-1:0]   diff_s;
    logic [EXT_W-1:0]   ext_l_s;
    logic [EXT_W-1:0]   ext_pre_s;
    logic [EXT_W-1:0]   ext_sh_s;
    logic [EXT_W-1:0]   lost_mask_s;
    logic [EXT_W-1:0]   ext_s_s;
    logic               eff_sub_s;
    logic [OUT_W-1:0]   sum_s;

    // Right-shift the smaller mantissa, folding every lost bit into sticky.
    always_comb begin
        diff_s      = s1_exp_l_r - s1_exp_s_r;
        ext_l_s     = {s1_man_l_r, 3'b000};
        ext_pre_s   = {s1_man_s_r, 3'b000};
        ext_sh_s    = ext_pre_s >> diff_s;
        lost_mask_s = ~({EXT_W{1'b1}} << diff_s);
        if (32'(diff_s) >= 32'(EXT_W)) begin
            ext_s_s = {{(EXT_W-1){1'b0}}, |s1_man_s_r};
        end else begin
            ext_s_s = {ext_sh_s[EXT_W-1:1], ext_sh_s[0] | (|(ext_pre_s & lost_mask_s))};
        end
        eff_sub_s = s1_sign_l_r ^ s1_sign_s_r;
        // |L| >= |S| so the subtraction never wraps.
        if (eff_sub_s) begin
            sum_s = {1'b0, ext_l_s} - {1'b0, ext_s_s};
        end else begin
            sum_s = {1'b0, ext_l_s} + {1'b0, ext_s_s};
        end
    end

    logic [OUT_W-1:0]   nxt_mant_s;
    logic [EXP_W-1:0]   nxt_exp_s;
    logic               nxt_sign_s;
    logic               nxt_zero_s;
`ifdef FPADD_SPECIAL_EN
    logic               nxt_nan_s;
    logic               nxt_inf_s;
    logic               nan_r;
    logic               inf_r;
`endif

    // Result selection: specials first, then exact-zero clean-up.
    always_comb begin
        nxt_mant_s = sum_s;
        nxt_exp_s  = s1_exp_l_r;
        nxt_sign_s = s1_sign_l_r;
        nxt_zero_s = 1'b0;
`ifdef FPADD_SPECIAL_EN
        nxt_nan_s  = 1'b0;
        nxt_inf_s  = 1'b0;
        if (s1_nan_r) begin
            nxt_nan_s  = 1'b1;
            nxt_mant_s = {OUT_W{1'b0}};
            nxt_exp_s  = {EXP_W{1'b1}};
            nxt_sign_s = 1'b0;
        end else if (s1_inf_r) begin
            nxt_inf_s  = 1'b1;
            nxt_mant_s = {OUT_W{1'b0}};
            nxt_exp_s  = {EXP_W{1'b1}};
            nxt_sign_s = s1_inf_sign_r;
        end else
`endif
        if (sum_s == {OUT_W{1'b0}}) begin
            nxt_mant_s = {OUT_W{1'b0}};
            nxt_exp_s  = {EXP_W{1'b0}};
            nxt_sign_s = 1'b0;
            nxt_zero_s = 1'b1;
        end else begin
            nxt_zero_s = 1'b0;
        end
    end

    // Output register; held while out_valid && !out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            mant_r      <= {OUT_W{1'b0}};
            exp_r       <= {EXP_W{1'b0}};
            sign_r      <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            if (s2_adv_s) begin
                out_valid_r <= s1_valid_r;
            end
            if (s2_load_s) begin
                mant_r <= nxt_mant_s;
                exp_r  <= nxt_exp_s;
                sign_r <= nxt_sign_s;
                zero_r <= nxt_zero_s;
            end
        end
    end

`ifdef FPADD_SPECIAL_EN
    // Special-case output flags, same timing as the data outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nan_r <= 1'b0;
            inf_r <= 1'b0;
        end else if (s2_load_s) begin
            nan_r <= nxt_nan_s;
            inf_r <= nxt_inf_s;
        end
    end

    assign bus.nan_out = nan_r;
    assign bus.inf_out = inf_r;
`endif

    assign bus.out_valid = out_valid_r;
    assign bus.mant_out  = mant_r;
    assign bus.exp_out   = exp_r;
    assign bus.sign_out  = sign_r;
    assign bus.zero_out  = zero_r;
endmodule

// File: tb/tb_fp_align_add_pipe.sv
// Directed, table-driven bench for fp_align_add_pipe (binary32 configuration).
// Builds with or without FPADD_SPECIAL_EN; the special-value rows follow the macro.
module tb_fp_align_add_pipe;
    logic clk;
    logic reset_n;

    fp_align_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_align_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [27:0] mant;
        logic [7:0]  expo;
        logic        sign;
        logic        zero;
        logic        nan;
        logic        inf;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [27:0] mant, input logic [7:0] expo, input logic sign,
                           input logic zero, input logic nan, input logic inf);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.mant = mant; v.expo = expo;
        v.sign = sign; v.zero = zero; v.nan = nan; v.inf = inf;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.op_a     = v.a;
        bus.op_b     = v.b;
        bus.op_sub   = v.sub;
    endtask

    // One isolated transaction with out_ready=1; called at posedge+1.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        drive(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd2);
        check({tag, " mant"}, 64'(bus.mant_out), 64'(v.mant));
        check({tag, " exp"}, 64'(bus.exp_out), 64'(v.expo));
        if (!v.nan) begin
            check({tag, " sign"}, 64'(bus.sign_out), 64'(v.sign));
        end
        check({tag, " zero"}, 64'(bus.zero_out), 64'(v.zero));
`ifdef FPADD_SPECIAL_EN
        check({tag, " nan"}, 64'(bus.nan_out), 64'(v.nan));
        check({tag, " inf"}, 64'(bus.inf_out), 64'(v.inf));
`endif
    endtask

    initial begin
        int  sidx[4];
        int  acc;
        int  oidx;
        bit  seen_low;
        bit  rdy;

        //       a             b             sub   mant           exp    sg    zr    nan   inf
        add_vec(32'h3F800000, 32'h3F800000, 1'b0, 28'h8000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 28'h0000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(32'h40000000, 32'hBF800000, 1'b0, 28'h2000000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h33800000, 1'b0, 28'h4000004, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h2B800000, 1'b0, 28'h4000001, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h40000000, 1'b0, 28'h6000000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h40000000, 1'b1, 28'h2000000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(32'h00000001, 32'h3F800000, 1'b0, 28'h4000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h00000000, 32'h80000000, 1'b0, 28'h0000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h2B800000, 1'b1, 28'h3FFFFFF, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'hBF800000, 32'hBF800000, 1'b0, 28'h8000000, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h33000000, 1'b0, 28'h4000002, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h40400000, 32'h3F800000, 1'b1, 28'h4000000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3FC00000, 32'h3FC00000, 1'b1, 28'h0000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(32'hBF800000, 32'h3F800000, 1'b0, 28'h0000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h33800001, 1'b0, 28'h4000005, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h32800000, 1'b0, 28'h4000001, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h32000000, 1'b0, 28'h4000001, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FPADD_SPECIAL_EN
        add_vec(32'h7F800000, 32'h7F800000, 1'b1, 28'h0000000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 28'h0000000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(32'hFF800000, 32'h3F800000, 1'b0, 28'h0000000, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 28'h0000000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(32'h3F800000, 32'h7F800000, 1'b1, 28'h0000000, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        add_vec(32'h7F800000, 32'h7F800000, 1'b0, 28'h8000000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'h7F800000, 32'h7F800000, 1'b1, 28'h0000000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 28'h4000001, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(32'hFF800000, 32'h3F800000, 1'b0, 28'h3FFFFFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 28'h6000001, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset state
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset mant", 64'(bus.mant_out), 64'd0);
        check("reset exp", 64'(bus.exp_out), 64'd0);
        check("reset zero", 64'(bus.zero_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);

        // Table vectors, one at a time
        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with out_ready low for the first 4 cycles
        sidx[0] = 0; sidx[1] = 2; sidx[2] = 5; sidx[3] = 9;
        acc = 0; oidx = 0; seen_low = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.out_ready = (cyc >= 4);
            if (acc < 4) begin
                drive(vq[sidx[acc]]);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            rdy = bus.in_ready;
            if (!rdy && !seen_low) begin
                seen_low = 1'b1;
                check("stream accepts before in_ready low", 64'(acc), 64'd2);
            end
            if (bus.out_valid && oidx < 4) begin
                check($sformatf("stream out%0d mant", oidx), 64'(bus.mant_out), 64'(vq[sidx[oidx]].mant));
                check($sformatf("stream out%0d exp", oidx), 64'(bus.exp_out), 64'(vq[sidx[oidx]].expo));
                check($sformatf("stream out%0d sign", oidx), 64'(bus.sign_out), 64'(vq[sidx[oidx]].sign));
                if (bus.out_ready) begin
                    oidx++;
                end
            end
            @(posedge clk);
            if (bus.in_valid && rdy) begin
                acc++;
            end
            #1;
        end
        check("stream in_ready fell", 64'(seen_low), 64'd1);
        check("stream accepted", 64'(acc), 64'd4);
        check("stream delivered", 64'(oidx), 64'd4);

        // Reset with two transactions in flight
        bus.out_ready = 1'b0;
        drive(vq[0]);
        @(posedge clk); #1;
        drive(vq[2]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("inflight out_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset mant", 64'(bus.mant_out), 64'd0);
        check("midreset exp", 64'(bus.exp_out), 64'd0);
        check("midreset sign", 64'(bus.sign_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("postreset out_valid", 64'(bus.out_valid), 64'd0);
        run_vec(vq[3], "postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
